// File: rtl/conv_result_collector.sv
// Frame buffer at the tail of the convolution datapath: collects one frame of
// results, then serves them over a request/valid read port. Optional macro: RESULT_RELU_EN.
module conv_result_collector #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [15:0]   convResult,
  input  logic                 enable,
  input  logic                 endSign,
  input  logic                 clear,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  output logic [15:0]          rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count,
  output logic                 overflow
);

  // state     | meaning
  // S_IDLE    | waiting for the first datum or frame end
  // S_COLLECT | storing results of the current frame
  // S_DONE    | frame closed, buffer readable
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, done_q;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic [15:0]   mem_q [DEPTH];

`ifdef RESULT_RELU_EN
  assign wr_data = convResult[15] ? 16'h0000 : convResult;
`else
  assign wr_data = convResult;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (clear) begin
      state_d    = S_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (enable) begin
            if (count_q < DEPTH_C) begin
              wr_en   = 1'b1;
              count_d = count_q + ONE_C;
            end else begin
              overflow_d = 1'b1;
            end
            state_d = S_COLLECT;
          end
          if (endSign) state_d = S_DONE;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Out-of-frame addresses read as zero rather than stale buffer contents.
  always_comb begin
    rd_valid_d = rd_req && (state_q == S_DONE) && !clear;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = ({1'b0, rd_addr} < count_q) ? mem_q[rd_addr] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d == S_COLLECT);
      done_q     <= (state_d == S_DONE);
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Buffer has no reset; only count_q defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[count_q[AW-1:0]] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed, table-driven bench for conv_result_collector plus a hand-written
// buffer-full sequence.
module tb_conv_result_collector;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

`ifdef RESULT_RELU_EN
  localparam logic [15:0] NEG2_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG2_EXP = 16'hFFFE;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, endSign, clear, rd_req;
  logic [15:0]   convResult;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          rd_valid, busy, done, overflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  conv_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .convResult(convResult), .enable(enable),
    .endSign(endSign), .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, clr, en, es;
    logic [15:0] din;
    logic        rq;
    logic [5:0]  ra;
    logic        ebusy, edone;
    logic [6:0]  ecnt;
    logic        eovf, erv, chkd;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic e, logic s, logic [15:0] d,
                              logic q, logic [5:0] a, logic eb, logic ed,
                              logic [6:0] ec, logic eo, logic ev, logic cd,
                              logic [15:0] edat);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.es = s; v.din = d; v.rq = q; v.ra = a;
    v.ebusy = eb; v.edone = ed; v.ecnt = ec; v.eovf = eo; v.erv = ev;
    v.chkd = cd; v.edata = edat;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic c, logic e, logic s, logic [15:0] d,
                       logic q, logic [5:0] a);
    @(negedge clk);
    rst = r; clear = c; enable = e; endSign = s; convResult = d;
    rd_req = q; rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, logic eb, logic ed, logic [6:0] ec,
                           logic eo, logic ev);
    chk("busy", idx, 32'(busy), 32'(eb));
    chk("done", idx, 32'(done), 32'(ed));
    chk("count", idx, 32'(count), 32'(ec));
    chk("overflow", idx, 32'(overflow), 32'(eo));
    chk("rd_valid", idx, 32'(rd_valid), 32'(ev));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b0; endSign = 1'b0;
    convResult = 16'h0; rd_req = 1'b0; rd_addr = '0;

    //          rst clr en es din       rq ra   busy done cnt ovf rv chkd data
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0003, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'hFFFE, 0, 0, 1, 0, 2, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0064, 0, 0, 1, 0, 3, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 4, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 1, 16'h7FFF, 0, 0, 0, 1, 5, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 5, 0, 1, 1, 16'h0003));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 5, 0, 1, 1, NEG2_EXP));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 2, 0, 1, 5, 0, 1, 1, 16'h0064));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 3, 0, 1, 5, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 4, 0, 1, 5, 0, 1, 1, 16'h7FFF));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 5, 0, 1, 5, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 5, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 1, 16'h1234, 0, 0, 0, 1, 5, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0011, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0022, 1, 1, 1, 0, 2, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 2, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 2, 0, 1, 1, 16'h0022));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 2, 0, 1, 1, 16'h0011));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0055, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0005, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0006, 0, 0, 1, 0, 2, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0007, 0, 0, 1, 0, 3, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0008, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0009, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 1, 0, 1, 1, 16'h0009));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].es, vecs[i].din,
            vecs[i].rq, vecs[i].ra);
      check_all(i, vecs[i].ebusy, vecs[i].edone, vecs[i].ecnt, vecs[i].eovf,
                vecs[i].erv);
      if (vecs[i].chkd) chk("rd_data", i, 32'(rd_data), 32'(vecs[i].edata));
    end

    // Buffer-full: DEPTH+2 data with values 1..DEPTH+2, then endSign alone.
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(0, 0, 1, 0, 16'(k + 1), 0, 0);
      if (k == DEPTH - 1) check_all(1000 + k, 1, 0, 7'(DEPTH), 0, 0);
    end
    check_all(1100, 1, 0, 7'(DEPTH), 1, 0);
    drive(0, 0, 0, 1, 16'h0, 0, 0);
    check_all(1101, 0, 1, 7'(DEPTH), 1, 0);
    drive(0, 0, 0, 0, 16'h0, 1, 6'(DEPTH - 1));
    check_all(1102, 0, 1, 7'(DEPTH), 1, 1);
    chk("rd_data_full_last", 1102, 32'(rd_data), 32'(DEPTH));
    drive(0, 0, 0, 0, 16'h0, 1, 6'd0);
    chk("rd_data_full_first", 1103, 32'(rd_data), 32'h1);
    drive(0, 1, 0, 0, 16'h0, 0, 0);
    check_all(1104, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Sink end of the convolution datapath. Accepts the 16-bit signed result stream with its `enable` strobe and `endSign` frame marker, stores one frame of results in an internal buffer, then serves them to a host/readback port through a request/valid read handshake. Sits directly after the add stage and is the only consumer of `convResult`.

## Interface
- `DEPTH`, 64, buffer entries (results per frame, max)
- `AW`, 6, address width; `2**AW >= DEPTH`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `convResult`  in  16  signed conv result, valid when `enable`=1
- `enable`  in  1  result-valid strobe, one datum per high cycle
- `endSign`  in  1  frame end; last datum (if `enable` also high) belongs to this frame
- `clear`  in  1  return to IDLE for a new frame
- `rd_req`  in  1  read request
- `rd_addr`  in  AW  read index
- `rd_data`  out  16  read data
- `rd_valid`  out  1  `rd_data` valid
- `busy`  out  1  high in COLLECT
- `done`  out  1  high in DONE
- `count`  out  AW+1  results stored this frame
- `overflow`  out  1  sticky; a datum was dropped because buffer full

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE: `enable`=1 writes `mem[0]`, `count`<=1, go COLLECT. `endSign`=1 (with or without `enable`) goes DONE; a concurrent datum is stored first.
- COLLECT: each `enable`=1 writes `mem[count]`, `count`++. `endSign`=1 goes DONE after storing any concurrent datum.
- DONE: `enable`/`endSign` ignored. Reads honoured. `clear` goes IDLE.
- `clear` in any state: next state IDLE, `count`<=0, `overflow`<=0; concurrent `enable` datum dropped, concurrent `endSign` ignored.
- Full: `enable` while `count`==DEPTH drops datum, `count` holds, `overflow`<=1. An `endSign` still ends the frame.
- Read: `rd_req`=1 in DONE -> next cycle `rd_valid`=1, `rd_data`=`mem[rd_addr]` if `rd_addr` < `count`, else 16'h0000. `rd_req` outside DONE is ignored (`rd_valid`=0 next cycle). Back-to-back requests are allowed, one per cycle.
- Stored value is `convResult` bit-exact (two's complement), except as described under Configuration.

## Timing
- All registers update on rising `clk`; `rst` has priority over `clear`, and `clear` over all other inputs.
- Reset values:
  - `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0.
  - State IDLE.
  - Buffer contents are not cleared.
- Write latency: datum sampled at edge N is readable in DONE from edge N+1 onward.
- `busy`/`done` are registered state decodes. `done` rises on the edge that samples `endSign`.
- Read latency: exactly 1 cycle. `rd_valid` is a single-cycle pulse per request.
- Reset mid-frame: frame discarded, IDLE next cycle. An in-flight read's `rd_valid` is suppressed.

## Configuration
- `RESULT_RELU_EN` defined: a datum with bit 15 set is stored as 16'h0000; non-negative values are unchanged.
- Not defined: raw signed value stored.
- `count`, `overflow` and the handshakes are identical in both builds.

## Test plan
- Reset then 5 `enable` pulses with values 3, -2, 100, 0, 7FFF, `endSign` with the 5th -> `done`=1, `count`=5; reads of idx 0..4 return 0003, FFFE, 0064, 0000, 7FFF (FFFE->0000 with `RESULT_RELU_EN`), each with `rd_valid` one cycle after `rd_req`.
- DEPTH+2 `enable` pulses then `endSign` -> `count`=DEPTH, `overflow`=1, `mem[DEPTH-1]` holds the DEPTH-th value.
- `rd_req` during COLLECT -> `rd_valid` stays 0. In DONE, `rd_addr`=`count` -> `rd_data`=0000, `rd_valid`=1.
- `endSign` alone in IDLE -> DONE, `count`=0. `clear` -> IDLE, `count`=0, `overflow`=0. A new 2-datum frame gives `count`=2.
- `rst` asserted after 3 datums mid-frame -> all outputs 0, IDLE. `clear`+`enable` in the same cycle -> datum dropped, `count`=0.
